fetch_pcgen_lb: RTL

- Parametrised next-generation fetch PC generator with a line-based instruction-SRAM request/grant/response handshake.
- Owns the architectural fetch PC and arbitrates redirects: branch-predict error, trap, mret, predicted jump.
- Reuses the currently held fetch line without a new request, fetches a second line for 32-bit instructions that straddle a line boundary, and discards in-flight responses killed by a redirect.
- Sits between decode/CSR bypass logic and the isram port.

---
 rtl/fetch_pcgen_lb_if.sv | 16 +
 rtl/fetch_pcgen_lb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_pcgen_lb_if.sv
// Line-based instruction-SRAM request/grant/response port.
// The fetch PC generator drives it as master; the SRAM side is the slave.
interface fetch_pcgen_lb_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 8
);
  localparam int LB = $clog2(LINE_BYTES);

  logic              req;
  logic [ADDR_W-LB-1:0] addr;
  logic              gnt;
  logic              rvalid;

  modport master (output req, output addr, input gnt, input rvalid);
  modport slave  (input req, input addr, output gnt, output rvalid);
endinterface

// File: rtl/fetch_pcgen_lb.sv
// Fetch PC generator: owns the fetch PC, arbitrates redirects and fetches
// instruction lines (including a second line for boundary-straddling ops).
module fetch_pcgen_lb #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 8,
  parameter int CAUSE_W    = 5,
  parameter int VEC_EN     = 1
) (
  input  logic               clk,
  input  logic               cpurst_n,
  input  logic [ADDR_W-1:0]  boot_addr,
  input  logic               stall,
  input  logic               bperr,
  input  logic [ADDR_W-1:0]  bperr_pc,
  input  logic               trap_req,
  input  logic               trap_int,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [ADDR_W-1:0]  mtvec,
  input  logic               mret_req,
  input  logic [ADDR_W-1:0]  mepc,
  input  logic               pred_taken,
  input  logic [ADDR_W-1:0]  pred_target,
  input  logic               cur_isrv16,
  fetch_pcgen_lb_if.master   ifu,
  output logic [ADDR_W-1:0]  pc,
  output logic               pc_valid,
  output logic               fet_flush,
  output logic               cross_ln
);
  localparam int LB = $clog2(LINE_BYTES);
  localparam int TW = ADDR_W - LB;

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ0  = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_REQ1  = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_VALID = 3'd5;

  logic [2:0]        state;
  logic [TW-1:0]     line0_tag, line1_tag;
  logic              line0_v, line1_v;
  logic              drop;

  logic [TW-1:0]     pc_line, npc_line;
  logic [ADDR_W-1:0] npc, redir_pc, mtvec_base;
  logic              pc_cross, need_ln1, in_req, in_wait, redirect, rsp_live;

  assign pc_line    = pc[ADDR_W-1:LB];
  assign pc_cross   = (&pc[LB-1:1]) && !cur_isrv16;
  assign need_ln1   = pc_cross && !line1_v;
  assign in_req     = (state == S_REQ0) || (state == S_REQ1);
  assign in_wait    = (state == S_WAIT0) || (state == S_WAIT1);
  assign redirect   = (state != S_BOOT) && (bperr || trap_req || mret_req);
  assign rsp_live   = ifu.rvalid && !drop && in_wait;
  assign mtvec_base = mtvec & ~ADDR_W'(3);

  assign npc      = (pred_taken ? pred_target
                                : pc + (cur_isrv16 ? ADDR_W'(2) : ADDR_W'(4))) & ~ADDR_W'(1);
  assign npc_line = npc[ADDR_W-1:LB];

  // Redirect target, highest priority first.
  always_comb begin
    redir_pc = mepc & ~ADDR_W'(1);
    if (bperr) begin
      redir_pc = bperr_pc;
    end else if (trap_req) begin
      if ((VEC_EN != 0) && (mtvec[1:0] == 2'b01) && trap_int)
        redir_pc = mtvec_base + (ADDR_W'(trap_cause) << 2);
      else
        redir_pc = mtvec_base;
    end
  end

  assign ifu.req   = in_req;
  assign ifu.addr  = (state == S_REQ1) ? line0_tag + TW'(1) : pc_line;
  assign pc_valid  = (state == S_VALID) && !need_ln1;
  assign cross_ln  = pc_valid && pc_cross;
  assign fet_flush = redirect;

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state     <= S_BOOT;
      pc        <= '0;
      line0_tag <= '0;
      line1_tag <= '0;
      line0_v   <= 1'b0;
      line1_v   <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (ifu.rvalid && drop)
        drop <= 1'b0;
      if (redirect) begin
        pc      <= redir_pc;
        line0_v <= 1'b0;
        line1_v <= 1'b0;
        state   <= S_REQ0;
        // A response consumed this very cycle needs no drop; a live one
        // still in flight (or granted now) must be discarded later.
        if ((in_req && ifu.gnt) || (in_wait && !(ifu.rvalid && !drop)))
          drop <= 1'b1;
      end else begin
        case (state)
          S_BOOT: begin
            pc    <= boot_addr;
            state <= S_REQ0;
          end
          S_REQ0: if (ifu.gnt) state <= S_WAIT0;
          S_WAIT0: if (rsp_live) begin
            line0_tag <= pc_line;
            line0_v   <= 1'b1;
            state     <= pc_cross ? S_REQ1 : S_VALID;
          end
          S_REQ1: if (ifu.gnt) state <= S_WAIT1;
          S_WAIT1: if (rsp_live) begin
            line1_tag <= line0_tag + TW'(1);
            line1_v   <= 1'b1;
            state     <= S_VALID;
          end
          S_VALID: begin
            // A jump within the held line can land on a straddling op.
            if (need_ln1) begin
              state <= S_REQ1;
            end else if (!stall) begin
              pc <= npc;
              if (line0_v && npc_line == line0_tag) begin
                state <= S_VALID;
              end else if (line1_v && npc_line == line1_tag) begin
                line0_tag <= line1_tag;
                line1_v   <= 1'b0;
              end else begin
                line0_v <= 1'b0;
                line1_v <= 1'b0;
                state   <= S_REQ0;
              end
            end
          end
          default: state <= S_BOOT;
        endcase
      end
    end
  end
endmodule
